// File: rtl/pipe_stage_gen.sv
// Chained pipeline latch for EX/MEM and later stage boundaries. Each stage can hold,
// flush to a bubble or advance. The block also provides a youngest-first forwarding
// lookup and saturating stall and bubble counters.
module pipe_stage_gen #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int CTRL_W   = 5,
  parameter int REGW_BIT = 0,
  parameter int STAGES   = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [ADDR_W-1:0] in_dst,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_wdata,
  output logic [ADDR_W-1:0] out_dst,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  output logic              fwd_a_hit,
  output logic              fwd_b_hit,
  output logic [DATA_W-1:0] fwd_a_data,
  output logic [DATA_W-1:0] fwd_b_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Handshake: in_valid marks a real instruction. There is no ready signal. stall is the
  // only back-pressure, and the upstream stage must hold its inputs while stall is high.
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              r_valid [STAGES];
  logic [DATA_W-1:0] r_alu   [STAGES];
  logic [DATA_W-1:0] r_wdata [STAGES];
  logic [ADDR_W-1:0] r_dst   [STAGES];
  logic [CTRL_W-1:0] r_ctrl  [STAGES];
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic              w_advance;
  logic              w_bubble_evt;

  assign w_advance    = !flush && !stall;
  assign w_bubble_evt = flush || (w_advance && !in_valid);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= 1'b0;
        r_alu[k]   <= '0;
        r_wdata[k] <= '0;
        r_dst[k]   <= '0;
        r_ctrl[k]  <= '0;
      end
    end else if (w_advance) begin
      // A bubble still captures data and dst. ctrl is forced to zero so nothing can leak.
      r_valid[0] <= in_valid;
      r_alu[0]   <= in_alu;
      r_wdata[0] <= in_wdata;
      r_dst[0]   <= in_dst;
      r_ctrl[0]  <= in_valid ? in_ctrl : '0;
      for (int k = 1; k < STAGES; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_alu[k]   <= r_alu[k-1];
        r_wdata[k] <= r_wdata[k-1];
        r_dst[k]   <= r_dst[k-1];
        r_ctrl[k]  <= r_ctrl[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (stall && !flush && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (w_bubble_evt && !(&r_bubble_cnt)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      end
    end
  end

  // Scan from oldest to youngest so the youngest matching stage wins.
  always_comb begin
    fwd_a_hit  = 1'b0;
    fwd_b_hit  = 1'b0;
    fwd_a_data = '0;
    fwd_b_data = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (r_valid[k] && r_ctrl[k][REGW_BIT] && (r_dst[k] == src_a) && (src_a != '0)) begin
        fwd_a_hit  = 1'b1;
        fwd_a_data = r_alu[k];
      end
      if (r_valid[k] && r_ctrl[k][REGW_BIT] && (r_dst[k] == src_b) && (src_b != '0)) begin
        fwd_b_hit  = 1'b1;
        fwd_b_data = r_alu[k];
      end
    end
  end

  assign out_valid  = r_valid[STAGES-1];
  assign out_alu    = r_alu[STAGES-1];
  assign out_wdata  = r_wdata[STAGES-1];
  assign out_dst    = r_dst[STAGES-1];
  assign out_ctrl   = r_ctrl[STAGES-1];
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;

endmodule
